alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Issuer/consumer on the other side of the ALU interface.
- Accepts one decoded operation per handshake: ALUOp, 11-bit LEGv8 opcode and two operands.
- Translates it to the 4-bit ALU control code and drives the clocked ALU.
- Waits for the registered result, captures result and zero flag, resolves CBZ/CBNZ, and returns one response per request.

Parameters:
- WIDTH, 64, operand/result width.
- OPC_W, 11, opcode field width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_aluop  in  2  ALUOp from main control.
- req_opcode  in  OPC_W  instruction opcode field.
- req_a  in  WIDTH  first operand.
- req_b  in  WIDTH  second operand.
- alu_ctrl  out  4  drives ALU control input.
- alu_a  out  WIDTH  drives ALU read_data_1.
- alu_b  out  WIDTH  drives ALU read_data_2.
- alu_result  in  WIDTH  ALU registered result.
- alu_zero  in  1  ALU registered zero flag.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_result  out  WIDTH  captured ALU result.
- resp_zero  out  1  captured zero flag.
- resp_taken  out  1  branch taken (CBZ/CBNZ only).
- resp_err  out  1  illegal ALUOp/opcode combination.

Behaviour:
- Reset (rst_n low, async): state IDLE; alu_ctrl=4'b0000; alu_a, alu_b, resp_result = 0; resp_zero, resp_taken, resp_err, resp_valid = 0; req_ready = 1 once out of reset.
- States: IDLE, EXEC, CAPT, RESP.
- IDLE: req_ready=1. On an edge with req_valid=1, decode, register alu_ctrl/alu_a/alu_b, latch opcode, then:
  - legal op: go EXEC.
  - illegal op: set resp_err=1, resp_result=0, resp_zero=0, resp_taken=0; go RESP. alu_* outputs keep their previous values.
- Decode:
  - ALUOp 00 (load/store): ctrl 0010; a=req_a, b=req_b.
  - ALUOp 01 (branch): ctrl 0110; a=req_a, b forced 0.
    - Legal only if opcode[10:3] = 8'b10110100 (CBZ) or 8'b10110101 (CBNZ); otherwise illegal.
  - ALUOp 10 (R-type):
    - 10001011000 -> 0010 (ADD)
    - 11001011000 -> 0110 (SUB)
    - 10001010000 -> 0000 (AND)
    - 10101010000 -> 0001 (ORR)
    - any other opcode -> illegal.
  - ALUOp 11: illegal.
- EXEC: the ALU samples alu_* on this edge; alu_* held stable; go CAPT.
- CAPT: capture alu_result/alu_zero into resp_result/resp_zero on this edge; resp_err=0.
  - resp_taken = alu_zero for CBZ, ~alu_zero for CBNZ, 0 otherwise.
  - Set resp_valid=1; go RESP.
- RESP: resp_valid=1 and all resp_* held stable until an edge with resp_ready=1; then resp_valid=0, go IDLE.
- Latency, legal op: accept edge E0, resp_valid high after E2. Illegal op: high after E0.
- Throughput: one request in flight. The next request is accepted no earlier than the edge after the response handshake.
- req_ready is low in EXEC/CAPT/RESP; req_valid there is ignored, with no side effects.
- resp_ready asserted outside RESP is ignored.
- Arithmetic: wraps modulo 2^WIDTH. The issuer does no arithmetic itself; results come only from the ALU.
- alu_* outputs hold their last values in IDLE/RESP, so the ALU result does not change between ops.
- rst_n asserted mid-operation (any state): immediate return to reset values; the in-flight op is dropped with no response.

Test Plan:
- Reset: rst_n low mid-EXEC -> all outputs 0 asynchronously, req_ready=1 after release, no resp_valid.
- R-type ADD: aluop=10, opcode=10001011000, a=5, b=7 -> alu_ctrl=0010; resp_valid 2 cycles after accept with result=12, zero=0, taken=0, err=0.
- SUB to zero: opcode=11001011000, a=b=64'hFFFF_FFFF_FFFF_FFFF -> result=0, zero=1. Same with a=0, b=1 -> result=64'hFFFF_FFFF_FFFF_FFFF (wrap).
- Branches:
  - CBZ (opcode 10110100xxx), a=0, b=99 -> alu_b=0, zero=1, taken=1.
  - CBNZ, a=3 -> zero=0, taken=1.
  - CBZ, a=3 -> taken=0.
- Illegal: aluop=11 -> resp_valid the cycle after accept, err=1, alu_ctrl unchanged. aluop=10, opcode=0 -> err=1.
- Backpressure: resp_ready low 5 cycles with AND a=F0, b=3C -> resp stable (result=30) all 5 cycles, req_ready=0, an extra req_valid ignored. Accepted only after the handshake.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues decoded LEGv8 ops to a clocked ALU and returns one response per request
module alu_issue_ctrl #(
    parameter int WIDTH = 64,
    parameter int OPC_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_aluop,
    input  logic [OPC_W-1:0] req_opcode,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_zero,
    output logic             resp_taken,
    output logic             resp_err
);
    typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

    state_t           state_q;
    logic [3:0]       alu_ctrl_q, ctrl_d;
    logic [WIDTH-1:0] alu_a_q, alu_b_q, b_d, resp_result_q;
    logic             legal_d, br_q, cbnz_q;
    logic             resp_valid_q, resp_zero_q, resp_taken_q, resp_err_q;
    logic [7:0]       br_field;

    assign br_field = req_opcode[OPC_W-1 -: 8];

    // Translate ALUOp/opcode into the ALU control code and second operand
    always_comb begin
        ctrl_d  = 4'b0010;
        b_d     = req_b;
        legal_d = 1'b0;
        case (req_aluop)
            2'b00: legal_d = 1'b1;
            2'b01: begin
                ctrl_d  = 4'b0110;
                b_d     = '0;
                legal_d = (br_field == 8'b10110100) || (br_field == 8'b10110101);
            end
            2'b10: begin
                legal_d = 1'b1;
                case (req_opcode)
                    11'b10001011000: ctrl_d = 4'b0010;
                    11'b11001011000: ctrl_d = 4'b0110;
                    11'b10001010000: ctrl_d = 4'b0000;
                    11'b10101010000: ctrl_d = 4'b0001;
                    default:         legal_d = 1'b0;
                endcase
            end
            default: legal_d = 1'b0;
        endcase
    end

    // Request/execute/capture/respond sequencer with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            alu_ctrl_q    <= 4'b0000;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            br_q          <= 1'b0;
            cbnz_q        <= 1'b0;
            resp_result_q <= '0;
            resp_zero_q   <= 1'b0;
            resp_taken_q  <= 1'b0;
            resp_err_q    <= 1'b0;
            resp_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    br_q   <= (req_aluop == 2'b01);
                    cbnz_q <= req_opcode[OPC_W-8];
                    if (legal_d) begin
                        alu_ctrl_q <= ctrl_d;
                        alu_a_q    <= req_a;
                        alu_b_q    <= b_d;
                        state_q    <= EXEC;
                    end else begin
                        resp_err_q    <= 1'b1;
                        resp_result_q <= '0;
                        resp_zero_q   <= 1'b0;
                        resp_taken_q  <= 1'b0;
                        resp_valid_q  <= 1'b1;
                        state_q       <= RESP;
                    end
                end
                EXEC: state_q <= CAPT;
                CAPT: begin
                    resp_result_q <= alu_result;
                    resp_zero_q   <= alu_zero;
                    resp_err_q    <= 1'b0;
                    resp_taken_q  <= br_q & (alu_zero ^ cbnz_q);
                    resp_valid_q  <= 1'b1;
                    state_q       <= RESP;
                end
                default: if (resp_ready) begin
                    resp_valid_q <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign alu_ctrl    = alu_ctrl_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign resp_valid  = resp_valid_q;
    assign resp_result = resp_result_q;
    assign resp_zero   = resp_zero_q;
    assign resp_taken  = resp_taken_q;
    assign resp_err    = resp_err_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed tests of alu_issue_ctrl against a clocked ALU model
module tb_alu_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_aluop = '0;
    logic [10:0] req_opcode = '0;
    logic [63:0] req_a = '0, req_b = '0;
    logic [3:0]  alu_ctrl;
    logic [63:0] alu_a, alu_b, alu_result = '0;
    logic        alu_zero = 1'b0;
    logic        resp_valid, resp_ready = 1'b0;
    logic [63:0] resp_result;
    logic        resp_zero, resp_taken, resp_err;
    int          checks = 0, fails = 0;
    int          lat;

    alu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_aluop(req_aluop), .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .alu_zero(alu_zero), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_zero(resp_zero), .resp_taken(resp_taken),
        .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    // Clocked ALU: registered result and zero flag
    always @(posedge clk) begin
        logic [63:0] r;
        r = (alu_ctrl == 4'b0010) ? alu_a + alu_b :
            (alu_ctrl == 4'b0110) ? alu_a - alu_b :
            (alu_ctrl == 4'b0000) ? (alu_a & alu_b) :
            (alu_ctrl == 4'b0001) ? (alu_a | alu_b) : 64'd0;
        alu_result <= r;
        alu_zero   <= (r == 64'd0);
    end

    task automatic issue(input logic [1:0] op, input logic [10:0] opc, input logic [63:0] a, input logic [63:0] b);
        int n = 0;
        while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
        req_aluop = op; req_opcode = opc; req_a = a; req_b = b; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int l);
        l = 0;
        while (!resp_valid && l < 10) begin @(posedge clk); #1; l++; end
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (resp_valid !== 1'b0 || alu_ctrl !== 4'd0 || alu_a !== 64'd0 || resp_result !== 64'd0) begin fails++; $display("FAIL reset_vals valid=%b ctrl=%h a=%h res=%h required 0", resp_valid, alu_ctrl, alu_a, resp_result); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b required 1", req_ready); end
        issue(2'b10, 11'b10001011000, 64'd5, 64'd7);
        checks++; if (alu_ctrl !== 4'b0010 || req_ready !== 1'b0) begin fails++; $display("FAIL reset_exec ctrl=%h ready=%b required 2/0", alu_ctrl, req_ready); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (alu_ctrl !== 4'd0 || alu_a !== 64'd0 || alu_b !== 64'd0 || resp_valid !== 1'b0 || resp_err !== 1'b0) begin fails++; $display("FAIL reset_async ctrl=%h a=%h b=%h valid=%b required 0", alu_ctrl, alu_a, alu_b, resp_valid); end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin fails++; $display("FAIL reset_drop ready=%b valid=%b required 1/0", req_ready, resp_valid); end
    endtask

    task automatic test_add();
        issue(2'b10, 11'b10001011000, 64'd5, 64'd7);
        checks++; if (alu_ctrl !== 4'b0010 || alu_a !== 64'd5 || alu_b !== 64'd7) begin fails++; $display("FAIL add_drive ctrl=%h a=%h b=%h required 2/5/7", alu_ctrl, alu_a, alu_b); end
        wait_resp(lat);
        checks++; if (lat !== 2) begin fails++; $display("FAIL add_latency got %0d required 2", lat); end
        checks++; if (resp_result !== 64'd12 || resp_zero !== 1'b0 || resp_taken !== 1'b0 || resp_err !== 1'b0) begin fails++; $display("FAIL add_resp res=%h z=%b t=%b e=%b required 12/0/0/0", resp_result, resp_zero, resp_taken, resp_err); end
        finish_resp();
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL add_handshake valid=%b ready=%b required 0/1", resp_valid, req_ready); end
    endtask

    task automatic test_sub();
        issue(2'b10, 11'b11001011000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        checks++; if (alu_ctrl !== 4'b0110) begin fails++; $display("FAIL sub_ctrl got %h required 6", alu_ctrl); end
        wait_resp(lat);
        checks++; if (lat !== 2 || resp_result !== 64'd0 || resp_zero !== 1'b1) begin fails++; $display("FAIL sub_zero lat=%0d res=%h z=%b required 2/0/1", lat, resp_result, resp_zero); end
        finish_resp();
        issue(2'b10, 11'b11001011000, 64'd0, 64'd1);
        wait_resp(lat);
        checks++; if (resp_result !== 64'hFFFF_FFFF_FFFF_FFFF || resp_zero !== 1'b0) begin fails++; $display("FAIL sub_wrap res=%h z=%b required all-ones/0", resp_result, resp_zero); end
        finish_resp();
    endtask

    task automatic test_branch();
        issue(2'b01, 11'b10110100101, 64'd0, 64'd99);
        checks++; if (alu_ctrl !== 4'b0110 || alu_b !== 64'd0) begin fails++; $display("FAIL cbz_drive ctrl=%h b=%h required 6/0", alu_ctrl, alu_b); end
        wait_resp(lat);
        checks++; if (resp_zero !== 1'b1 || resp_taken !== 1'b1 || resp_err !== 1'b0) begin fails++; $display("FAIL cbz_taken z=%b t=%b e=%b required 1/1/0", resp_zero, resp_taken, resp_err); end
        finish_resp();
        issue(2'b01, 11'b10110101000, 64'd3, 64'd0);
        wait_resp(lat);
        checks++; if (resp_zero !== 1'b0 || resp_taken !== 1'b1 || resp_result !== 64'd3) begin fails++; $display("FAIL cbnz_taken z=%b t=%b res=%h required 0/1/3", resp_zero, resp_taken, resp_result); end
        finish_resp();
        issue(2'b01, 11'b10110100000, 64'd3, 64'd0);
        wait_resp(lat);
        checks++; if (resp_zero !== 1'b0 || resp_taken !== 1'b0) begin fails++; $display("FAIL cbz_not_taken z=%b t=%b required 0/0", resp_zero, resp_taken); end
        finish_resp();
    endtask

    task automatic test_illegal();
        issue(2'b11, 11'b10001011000, 64'd1, 64'd2);
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || alu_ctrl !== 4'b0110 || alu_a !== 64'd3) begin fails++; $display("FAIL illegal_op11 valid=%b err=%b ctrl=%h a=%h required 1/1/6/3", resp_valid, resp_err, alu_ctrl, alu_a); end
        checks++; if (resp_result !== 64'd0 || resp_zero !== 1'b0 || resp_taken !== 1'b0) begin fails++; $display("FAIL illegal_resp res=%h z=%b t=%b required 0/0/0", resp_result, resp_zero, resp_taken); end
        finish_resp();
        issue(2'b10, 11'b00000000000, 64'd1, 64'd2);
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || alu_ctrl !== 4'b0110) begin fails++; $display("FAIL illegal_rtype valid=%b err=%b ctrl=%h required 1/1/6", resp_valid, resp_err, alu_ctrl); end
        finish_resp();
        issue(2'b01, 11'b10001011000, 64'd1, 64'd2);
        checks++; if (resp_err !== 1'b1 || resp_valid !== 1'b1) begin fails++; $display("FAIL illegal_branch err=%b valid=%b required 1/1", resp_err, resp_valid); end
        finish_resp();
    endtask

    task automatic test_back_to_back();
        issue(2'b10, 11'b10001010000, 64'hF0, 64'h3C);
        wait_resp(lat);
        req_aluop = 2'b10; req_opcode = 11'b10001011000; req_a = 64'd1; req_b = 64'd1; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (resp_valid !== 1'b1 || resp_result !== 64'h30 || req_ready !== 1'b0 || alu_ctrl !== 4'b0000) begin fails++; $display("FAIL bp_hold%0d valid=%b res=%h ready=%b ctrl=%h required 1/30/0/0", i, resp_valid, resp_result, req_ready, alu_ctrl); end
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || alu_ctrl !== 4'b0000) begin fails++; $display("FAIL bp_handshake valid=%b ready=%b ctrl=%h required 0/1/0", resp_valid, req_ready, alu_ctrl); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (alu_ctrl !== 4'b0010 || req_ready !== 1'b0) begin fails++; $display("FAIL bp_accept ctrl=%h ready=%b required 2/0", alu_ctrl, req_ready); end
        wait_resp(lat);
        checks++; if (lat !== 2 || resp_result !== 64'd2) begin fails++; $display("FAIL bp_next lat=%0d res=%h required 2/2", lat, resp_result); end
        finish_resp();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_branch();
        test_illegal();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
